// File: rtl/sata_tx_crc_ctrl_if.sv
// FIS dword stream between the transport TX FIFO, the CRC sequencer and the link TX mux.
// The slave modport is the sequencer's view; master is the surrounding transport/link side.
interface sata_tx_crc_ctrl_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_eop;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_crc;
  logic        out_ready;

  modport master (
    output in_data, in_valid, in_eop, out_ready,
    input  in_ready, out_data, out_valid, out_crc
  );

  modport slave (
    input  in_data, in_valid, in_eop, out_ready,
    output in_ready, out_data, out_valid, out_crc
  );
endinterface

// File: rtl/sata_tx_crc_ctrl.sv
// SATA link TX CRC sequencer: passes FIS dwords through with zero latency, clocks the
// external CRC engine once per accepted dword and appends the final CRC dword.
module sata_tx_crc_ctrl #(
  parameter int MAX_DW = 2049,
  parameter int CNT_W  = 16
) (
  input  logic               clk_75m,
  input  logic               rst_n,
  sata_tx_crc_ctrl_if.slave  tx,
  input  logic               abort,
  output logic               crc_rst,
  output logic [31:0]        crc_data,
  output logic               crc_valid,
  input  logic [31:0]        crc_in,
  output logic               err_len,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int DW_W = $clog2(MAX_DW + 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(MAX_DW - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_DATA,
    ST_CRC
  } state_t;

  state_t           state, state_nxt;
  logic [DW_W-1:0]  dw_cnt, dw_cnt_nxt;
  logic [CNT_W-1:0] frame_cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset returns the block to INIT mid-frame.
  always_ff @(posedge clk_75m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      dw_cnt    <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      dw_cnt    <= dw_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    dw_cnt_nxt    = dw_cnt;
    frame_cnt_nxt = frame_cnt;
    tx.in_ready   = 1'b0;
    tx.out_valid  = 1'b0;
    tx.out_data   = '0;
    tx.out_crc    = 1'b0;
    crc_rst       = 1'b0;
    crc_data      = tx.in_data;
    crc_valid     = 1'b0;
    err_len       = 1'b0;

    unique case (state)
      ST_INIT: begin
        // Reseed the engine; abort is ignored here since the reseed is already happening.
        crc_rst   = 1'b1;
        crc_data  = '0;
        state_nxt = ST_IDLE;
      end

      ST_IDLE, ST_DATA: begin
        tx.out_data = tx.in_data;
        if (abort) begin
          state_nxt  = ST_INIT;
          dw_cnt_nxt = '0;
        end else begin
          tx.out_valid = tx.in_valid;
          tx.in_ready  = tx.out_ready;
          crc_valid    = tx.in_valid & tx.out_ready;
          if (crc_valid) begin
            dw_cnt_nxt = dw_cnt + 1'b1;
            if (tx.in_eop || dw_cnt == DW_LAST) begin
              // A frame hitting the length limit is closed with a CRC like a normal one.
              err_len   = ~tx.in_eop & (dw_cnt == DW_LAST);
              state_nxt = ST_CRC;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
      end

      ST_CRC: begin
        if (abort) begin
          state_nxt  = ST_INIT;
          dw_cnt_nxt = '0;
        end else begin
          tx.out_valid = 1'b1;
          tx.out_crc   = 1'b1;
          tx.out_data  = crc_in;
          if (tx.out_ready) begin
            // Reseed in the same cycle so the next frame can start immediately.
            crc_rst       = 1'b1;
            frame_cnt_nxt = frame_cnt + 1'b1;
            dw_cnt_nxt    = '0;
            state_nxt     = ST_IDLE;
          end
        end
      end

      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_sata_tx_crc_ctrl.sv
// Directed bench for sata_tx_crc_ctrl with a behavioural CRC engine and a bit-serial golden CRC.
// DUT a uses default parameters; DUT b uses MAX_DW=4, CNT_W=2 for the length-limit and wrap cases.
module tb_sata_tx_crc_ctrl;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SEED = 32'h5232_5032;

  logic clk_75m = 1'b0;
  logic rst_n   = 1'b0;
  always #7 clk_75m = ~clk_75m;

  int checks = 0;
  int errors = 0;

  sata_tx_crc_ctrl_if a_if ();
  sata_tx_crc_ctrl_if b_if ();

  logic        abort_a = 1'b0, abort_b = 1'b0;
  logic        crc_rst_a, crc_rst_b, crc_valid_a, crc_valid_b, err_len_a, err_len_b;
  logic [31:0] crc_data_a, crc_data_b, eng_a, eng_b;
  logic [15:0] frame_cnt_a;
  logic [1:0]  frame_cnt_b;

  sata_tx_crc_ctrl u_dut_a (
    .clk_75m(clk_75m), .rst_n(rst_n), .tx(a_if.slave), .abort(abort_a),
    .crc_rst(crc_rst_a), .crc_data(crc_data_a), .crc_valid(crc_valid_a),
    .crc_in(eng_a), .err_len(err_len_a), .frame_cnt(frame_cnt_a)
  );

  sata_tx_crc_ctrl #(.MAX_DW(4), .CNT_W(2)) u_dut_b (
    .clk_75m(clk_75m), .rst_n(rst_n), .tx(b_if.slave), .abort(abort_b),
    .crc_rst(crc_rst_b), .crc_data(crc_data_b), .crc_valid(crc_valid_b),
    .crc_in(eng_b), .err_len(err_len_b), .frame_cnt(frame_cnt_b)
  );

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = r << 1;
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] w [8], input int n);
    logic [31:0] c;
    c = SEED;
    for (int i = 0; i < n; i++) c = crc_step(c, w[i]);
    return c;
  endfunction

  // Behavioural stand-ins for the external CRC engines.
  always @(posedge clk_75m or negedge rst_n) begin
    if (!rst_n)           eng_a <= SEED;
    else if (crc_rst_a)   eng_a <= SEED;
    else if (crc_valid_a) eng_a <= crc_step(eng_a, crc_data_a);
  end

  always @(posedge clk_75m or negedge rst_n) begin
    if (!rst_n)           eng_b <= SEED;
    else if (crc_rst_b)   eng_b <= SEED;
    else if (crc_valid_b) eng_b <= crc_step(eng_b, crc_data_b);
  end

  int vcnt_a = 0;
  always @(posedge clk_75m) if (crc_valid_a) vcnt_a <= vcnt_a + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One frame on DUT a with out_ready held high, followed by its CRC beat.
  task automatic run_frame_a(input logic [31:0] w [8], input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_75m);
      a_if.in_valid = 1'b1; a_if.in_data = w[i]; a_if.in_eop = (i == n - 1); a_if.out_ready = 1'b1;
      #1;
      check({tag, "_dat"}, a_if.out_data, w[i]);
      check({tag, "_beat"}, 32'(a_if.out_valid & a_if.in_ready & crc_valid_a & ~a_if.out_crc), 1);
    end
    @(negedge clk_75m);
    a_if.in_valid = 1'b0; a_if.in_eop = 1'b0; a_if.in_data = '0;
    #1;
    check({tag, "_crc"}, a_if.out_data, golden(w, n));
    check({tag, "_crcbeat"}, 32'(a_if.out_valid & a_if.out_crc & ~a_if.in_ready & crc_rst_a), 1);
  endtask

  task automatic run_single_b(input logic [31:0] d, input string tag);
    logic [31:0] w [8];
    w = '{d, 0, 0, 0, 0, 0, 0, 0};
    @(negedge clk_75m);
    b_if.in_valid = 1'b1; b_if.in_data = d; b_if.in_eop = 1'b1; b_if.out_ready = 1'b1;
    @(negedge clk_75m);
    b_if.in_valid = 1'b0; b_if.in_eop = 1'b0;
    #1;
    check({tag, "_crc"}, b_if.out_data, golden(w, 1));
  endtask

  logic [31:0] w1 [8], w2 [8], w3a [8], w3b [8], w5 [8], w4 [8];
  logic [31:0] crc_hold;
  int          k, c, vstart;

  initial begin
    w1  = '{32'h0000_0000, 0, 0, 0, 0, 0, 0, 0};
    w2  = '{32'h0000_8027, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 0, 0, 0};
    w3a = '{32'h0000_0046, 32'h0102_0304, 32'h8000_0001, 0, 0, 0, 0, 0};
    w3b = '{32'hCAFE_F00D, 32'h0F0F_0F0F, 32'h7654_3210, 32'h0000_0001, 0, 0, 0, 0};
    w5  = '{32'h1111_2222, 32'h3333_4444, 0, 0, 0, 0, 0, 0};
    w4  = '{32'h0000_0039, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003,
            32'hAAAA_0004, 32'hAAAA_0005, 0, 0};
    a_if.in_valid = 0; a_if.in_data = '0; a_if.in_eop = 0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.in_data = '0; b_if.in_eop = 0; b_if.out_ready = 0;

    // Reset values while rst_n is held low, even with traffic offered.
    @(negedge clk_75m);
    a_if.in_valid = 1'b1; a_if.in_data = 32'h5555_AAAA; a_if.out_ready = 1'b1;
    @(negedge clk_75m);
    #1;
    check("rst_outs", 32'({a_if.out_valid, a_if.in_ready, crc_valid_a, err_len_a, a_if.out_crc}), 0);
    check("rst_odata", a_if.out_data, 0);
    check("rst_cdata", crc_data_a, 0);
    check("rst_fcnt", 32'(frame_cnt_a), 0);

    // Release: one INIT cycle with crc_rst high and nothing accepted.
    rst_n = 1'b1;
    #1;
    check("init_crcrst", 32'(crc_rst_a), 1);
    check("init_ready", 32'(a_if.in_ready), 0);
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    @(negedge clk_75m);
    #1;
    check("idle_crcrst", 32'(crc_rst_a), 0);
    check("idle_ready", 32'(a_if.in_ready), 1);

    // Test 1: single zero dword.
    run_frame_a(w1, 1, "t1");
    @(negedge clk_75m);
    #1;
    check("t1_fcnt", 32'(frame_cnt_a), 1);

    // Test 2: 5 dwords with out_ready toggling 1,0,1,0...
    vstart = vcnt_a;
    k = 0; c = 0;
    while (k < 5) begin
      @(negedge clk_75m);
      a_if.in_valid = 1'b1; a_if.in_data = w2[k]; a_if.in_eop = (k == 4); a_if.out_ready = (c % 2 == 0);
      #1;
      check("t2_dat", a_if.out_data, w2[k]);
      check("t2_cvld", 32'(crc_valid_a), (c % 2 == 0) ? 1 : 0);
      if (c % 2 == 0) k++;
      c++;
    end
    @(negedge clk_75m);
    a_if.in_valid = 1'b0; a_if.in_eop = 1'b0; a_if.out_ready = 1'b0;
    #1;
    crc_hold = a_if.out_data;
    check("t2_crc", crc_hold, golden(w2, 5));
    check("t2_stall", 32'({a_if.out_valid, a_if.out_crc, crc_rst_a}), 32'b110);
    @(negedge clk_75m);
    #1;
    check("t2_hold", a_if.out_data, golden(w2, 5));
    a_if.out_ready = 1'b1;
    #1;
    check("t2_accept", 32'(crc_rst_a), 1);
    @(negedge clk_75m);
    #1;
    check("t2_vcnt", 32'(vcnt_a - vstart), 5);
    check("t2_fcnt", 32'(frame_cnt_a), 2);

    // Test 3: back-to-back 3 + 4 dword frames, every cycle an out beat.
    run_frame_a(w3a, 3, "t3a");
    run_frame_a(w3b, 4, "t3b");
    @(negedge clk_75m);
    #1;
    check("t3_fcnt", 32'(frame_cnt_a), 4);

    // Test 5: abort on the 3rd beat of a 5-dword frame.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_75m);
      a_if.in_valid = 1'b1; a_if.in_data = w2[i]; a_if.in_eop = 1'b0; a_if.out_ready = 1'b1;
    end
    @(negedge clk_75m);
    a_if.in_data = w2[2]; abort_a = 1'b1;
    #1;
    check("t5_abort", 32'({a_if.in_ready, a_if.out_valid, crc_valid_a}), 0);
    @(negedge clk_75m);
    abort_a = 1'b0; a_if.in_valid = 1'b0;
    #1;
    check("t5_reseed", 32'({crc_rst_a, a_if.out_valid, a_if.out_crc}), 32'b100);
    check("t5_fcnt", 32'(frame_cnt_a), 4);
    run_frame_a(w5, 2, "t5");
    @(negedge clk_75m);
    #1;
    check("t5_fcnt2", 32'(frame_cnt_a), 5);

    // Test 6: 2-bit frame counter wraps.
    run_single_b(32'h0000_0001, "t6a");
    @(negedge clk_75m); #1; check("t6_fcnt1", 32'(frame_cnt_b), 1);
    run_single_b(32'h0000_0002, "t6b");
    @(negedge clk_75m); #1; check("t6_fcnt2", 32'(frame_cnt_b), 2);
    run_single_b(32'h0000_0003, "t6c");
    @(negedge clk_75m); #1; check("t6_fcnt3", 32'(frame_cnt_b), 3);
    run_single_b(32'h0000_0004, "t6d");
    @(negedge clk_75m); #1; check("t6_fcnt0", 32'(frame_cnt_b), 0);
    run_single_b(32'h0000_0005, "t6e");
    @(negedge clk_75m); #1; check("t6_fcnt1b", 32'(frame_cnt_b), 1);

    // Test 4: MAX_DW=4, 6 dwords without eop.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_75m);
      b_if.in_valid = 1'b1; b_if.in_data = w4[i]; b_if.in_eop = 1'b0; b_if.out_ready = 1'b1;
      #1;
      check("t4_err", 32'(err_len_b), (i == 3) ? 1 : 0);
      check("t4_rdy", 32'(b_if.in_ready), 1);
    end
    @(negedge clk_75m);
    b_if.in_data = w4[4];
    #1;
    check("t4_crc", b_if.out_data, golden(w4, 4));
    check("t4_crcbeat", 32'({b_if.out_crc, b_if.in_ready, err_len_b, crc_valid_b}), 32'b1000);
    @(negedge clk_75m);
    #1;
    check("t4_d5", b_if.out_data, w4[4]);
    check("t4_d5beat", 32'({b_if.out_crc, crc_valid_b}), 32'b01);
    @(negedge clk_75m);
    b_if.in_data = w4[5];
    #1;
    check("t4_d6", b_if.out_data, w4[5]);
    @(negedge clk_75m);
    b_if.in_valid = 1'b0; abort_b = 1'b1;
    @(negedge clk_75m);
    abort_b = 1'b0;
    #1;
    check("t4_reseed", 32'(crc_rst_b), 1);
    check("t4_fcnt", 32'(frame_cnt_b), 2);

    // rst_n mid-frame: outputs return to reset values without a clock edge.
    @(negedge clk_75m);
    a_if.in_valid = 1'b1; a_if.in_data = 32'h0BAD_F00D; a_if.in_eop = 1'b0; a_if.out_ready = 1'b1;
    @(negedge clk_75m);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({a_if.out_valid, a_if.in_ready, crc_valid_a, err_len_a, a_if.out_crc}), 0);
    check("mid_rst_data", a_if.out_data | crc_data_a, 0);
    check("mid_rst_fcnt", 32'({frame_cnt_a, 14'd0, frame_cnt_b}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
